effect_tap_mixer: RTL and testbench
===================================

# effect_tap_mixer

Sample-rate effect engine between the sample memory and the MCU SPI output shift register. On each sample strobe it reads up to two delayed taps (reverb, chorus) from the circular sample buffer and mixes them with the dry ADC sample using saturating signed arithmetic. It then presents one 16-bit output word with a valid pulse for the MCU shift register to load.

## Interface

- `ADDR_W`, 16: sample buffer address width; buffer depth is 2^ADDR_W.
- `DATA_W`, 12: ADC sample width, offset-binary.
- `REV_DELAY`, 4800: reverb tap distance in samples; must be 1 .. 2^ADDR_W-1.
- `CHOR_BASE`, 600: chorus tap base distance in samples.
- `CHOR_DEPTH`, 120: chorus LFO peak excursion in samples; requires CHOR_BASE+CHOR_DEPTH < 2^ADDR_W.

- `clk`, in, 1: system clock (fpga_sck domain).
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle sample strobe.
- `wr_address`, in, ADDR_W: buffer address holding the newest sample; stable while busy.
- `dry_sample`, in, DATA_W: current ADC sample.
- `chorus_on`, in, 1: enable chorus tap.
- `reverb_on`, in, 1: enable reverb tap.
- `mem_addr`, out, ADDR_W: tap read address.
- `mem_rd`, out, 1: read strobe. The memory returns data one cycle later.
- `mem_data`, in, 16: memory read data; bits [DATA_W-1:0] are used.
- `mix_out`, out, 16: mixed sample, zero-extended offset-binary.
- `mix_valid`, out, 1: one-cycle pulse when `mix_out` is updated.
- `busy`, out, 1: high in any state other than IDLE.
- `overrun`, out, 1: one-cycle pulse when `start` arrives while busy.

## Operation

- States:
  - IDLE → REV_RD → REV_CAP → CHOR_RD → CHOR_CAP → SUM → DONE → IDLE.
  - A disabled tap's RD/CAP pair is skipped.
- In IDLE, `start` latches `dry_sample`, `chorus_on` and `reverb_on`. Mid-sample changes to the enable inputs have no effect.
- In RD states, `mem_rd`=1 and `mem_addr` is driven for one cycle.
  - Reverb address: `wr_address` − REV_DELAY, modulo 2^ADDR_W.
  - Chorus address: `wr_address` − (CHOR_BASE + lfo), modulo 2^ADDR_W.
- In CAP states, `mem_data[DATA_W-1:0]` is registered.
- In SUM:
  - Convert each operand to signed: s = x − 2^(DATA_W-1).
  - acc = dry + (rev >>> 1) + (chor >>> 1), using arithmetic shift. A disabled tap contributes 0.
  - acc is DATA_W+2 bits wide and saturates to [−2048, 2047].
  - Re-bias the result to offset binary and register it into `mix_out`.
- In DONE, `mix_valid`=1 for one cycle, then the block returns to IDLE.
- `start` while busy: ignored, and `overrun` pulses in the same cycle.

## Timing

- Reset values: all outputs 0 and state IDLE. Internally, lfo=0 and direction up.
- Latency from `start` (cycle 0) to `mix_valid`:
  - Both taps on: cycle 6.
  - One tap on: cycle 4.
  - Neither on: cycle 2.
- `mix_out` holds its value until the next DONE.
- Reset asserted mid-operation: the block returns to IDLE immediately. No `mix_valid` is produced and the partial result is discarded.
- LFO:
  - Steps once per DONE in which chorus was latched on; otherwise it holds.
  - Triangle waveform from 0 to CHOR_DEPTH.
  - Direction reverses on reaching either endpoint, so each endpoint is visited once per period.

## Configuration

- `CHORUS_LFO_EN` defined: chorus offset = CHOR_BASE + lfo, and the LFO triangle runs as above.
- `CHORUS_LFO_EN` undefined: the LFO register and its logic are absent, and the chorus offset is fixed at CHOR_BASE.

## Test plan

- Reverb only, dry=0x900, rev=0xA00: `mix_valid` at cycle 4 and `mix_out`=0x0A00; `mem_addr` = `wr_address` − 4800 while `mem_rd`=1.
- Both taps on, dry=rev=chor=0xFFF: result saturates to `mix_out`=0x0FFF. With all three at 0x000: result saturates to 0x0000. Latency is 6 cycles in both cases.
- Wrap-around, `wr_address`=0x0005 and REV_DELAY=16: reverb read address is 0xFFF5.
- LFO, CHOR_DEPTH=4, chorus on for 10 samples: chorus offsets are CHOR_BASE + 0,1,2,3,4,3,2,1,0,1. Without `CHORUS_LFO_EN`, the offset is constant CHOR_BASE.
- `start` reasserted at cycle 2 of a both-taps sample: `overrun` pulses at cycle 2 and the in-flight result still completes at cycle 6.
- Reset pulsed at cycle 3: `busy`=0, no `mix_valid`, and the next `start` completes normally.

Source files
------------

// File: rtl/effect_tap_mixer.sv
// Effect tap mixer: per sample strobe, reads reverb/chorus taps from the circular
// sample buffer and mixes them with the dry sample. Option macro: CHORUS_LFO_EN.
module effect_tap_mixer #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 12,
  parameter int REV_DELAY  = 4800,
  parameter int CHOR_BASE  = 600,
  parameter int CHOR_DEPTH = 120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic [DATA_W-1:0] dry_sample,
  input  logic              chorus_on,
  input  logic              reverb_on,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_data,
  output logic [15:0]       mix_out,
  output logic              mix_valid,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE, REV_RD, REV_CAP, CHOR_RD, CHOR_CAP, SUM, DONE
  } state_t;

  localparam int ACC_W = DATA_W + 2;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(DATA_W-1)));

  state_t              state;
  logic [DATA_W-1:0]   dry_q, rev_q, chor_q;
  logic                rev_en, chor_en;
  logic [ADDR_W-1:0]   chor_offset;
  logic [ADDR_W-1:0]   rev_addr, chor_addr;
  logic [DATA_W-1:0]   mix_word;
  logic signed [ACC_W-1:0] dry_s, rev_s, chor_s, acc;
  logic                mem_data_unused;

  assign mem_data_unused = ^mem_data[15:DATA_W];

  // Overrun must flag the very cycle the stray strobe arrives, so it is not registered.
  assign overrun = start & busy;

  assign rev_addr  = wr_address - ADDR_W'(REV_DELAY);
  assign chor_addr = wr_address - chor_offset;

`ifdef CHORUS_LFO_EN
  logic [ADDR_W-1:0] lfo;
  logic              lfo_up;

  assign chor_offset = ADDR_W'(CHOR_BASE) + lfo;

  // Triangle 0..CHOR_DEPTH; advances only after a sample that actually used the chorus tap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfo    <= '0;
      lfo_up <= 1'b1;
    end else if (state == DONE && chor_en && CHOR_DEPTH > 0) begin
      if (lfo_up) begin
        lfo <= lfo + 1'b1;
        if (lfo + 1'b1 == ADDR_W'(CHOR_DEPTH)) lfo_up <= 1'b0;
      end else begin
        lfo <= lfo - 1'b1;
        if (lfo == ADDR_W'(1)) lfo_up <= 1'b1;
      end
    end
  end
`else
  assign chor_offset = ADDR_W'(CHOR_BASE);
`endif

  // Offset-binary to two's complement is an MSB flip; sign-extend to accumulator width.
  function automatic logic signed [ACC_W-1:0] to_signed(input logic [DATA_W-1:0] x);
    return $signed({{2{~x[DATA_W-1]}}, ~x[DATA_W-1], x[DATA_W-2:0]});
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dry_s  = to_signed(dry_q);
    rev_s  = '0;
    chor_s = '0;
    if (rev_en)  rev_s  = to_signed(rev_q) >>> 1;
    if (chor_en) chor_s = to_signed(chor_q) >>> 1;
    acc = dry_s + rev_s + chor_s;
    if (acc > SAT_MAX)      mix_word = '1;
    else if (acc < SAT_MIN) mix_word = '0;
    else                    mix_word = {~acc[DATA_W-1], acc[DATA_W-2:0]};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      dry_q     <= '0;
      rev_q     <= '0;
      chor_q    <= '0;
      rev_en    <= 1'b0;
      chor_en   <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_rd    <= 1'b0;
      mix_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dry_q   <= dry_sample;
            rev_en  <= reverb_on;
            chor_en <= chorus_on;
            busy    <= 1'b1;
            if (reverb_on) begin
              state    <= REV_RD;
              mem_rd   <= 1'b1;
              mem_addr <= rev_addr;
            end else if (chorus_on) begin
              state    <= CHOR_RD;
              mem_rd   <= 1'b1;
              mem_addr <= chor_addr;
            end else begin
              state <= SUM;
            end
          end
        end
        REV_RD:  state <= REV_CAP;
        REV_CAP: begin
          rev_q <= mem_data[DATA_W-1:0];
          if (chor_en) begin
            state    <= CHOR_RD;
            mem_rd   <= 1'b1;
            mem_addr <= chor_addr;
          end else begin
            state <= SUM;
          end
        end
        CHOR_RD:  state <= CHOR_CAP;
        CHOR_CAP: begin
          chor_q <= mem_data[DATA_W-1:0];
          state  <= SUM;
        end
        SUM: begin
          mix_out   <= 16'(mix_word);
          mix_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_effect_tap_mixer.sv
// Scoreboard bench for effect_tap_mixer: stimulus pushes expected words/addresses,
// monitors pop and compare whenever the DUT presents mix_valid or mem_rd.
module tb_effect_tap_mixer;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 12;
  localparam int REV_DELAY  = 4800;
  localparam int CHOR_BASE  = 600;
  localparam int CHOR_DEPTH = 4;

  typedef struct {
    logic [15:0] mix;
    int          start_cyc;
    int          lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset, start, chorus_on, reverb_on;
  logic [ADDR_W-1:0] wr_address, mem_addr;
  logic [DATA_W-1:0] dry_sample;
  logic              mem_rd, mix_valid, busy, overrun;
  logic [15:0]       mem_data = '0;
  logic [15:0]       mix_out;

  logic [15:0] mem [0:65535];
  exp_t        exp_q[$];
  logic [15:0] addr_q[$];
  exp_t        mon_e;
  logic [15:0] mon_a;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          chor_count = 0;
  int          valid_count = 0;
  int          vc;

  effect_tap_mixer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REV_DELAY(REV_DELAY),
    .CHOR_BASE(CHOR_BASE), .CHOR_DEPTH(CHOR_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .wr_address(wr_address),
    .dry_sample(dry_sample), .chorus_on(chorus_on), .reverb_on(reverb_on),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: signed conversion, half-weight taps, clamp, re-bias.
  function automatic logic [15:0] model_mix(input int d, input int r, input int c,
                                            input bit ren, input bit cen);
    int acc;
    acc = d - 2048;
    if (ren) acc += (r - 2048) >>> 1;
    if (cen) acc += (c - 2048) >>> 1;
    if (acc > 2047)  acc = 2047;
    if (acc < -2048) acc = -2048;
    return 16'(acc + 2048);
  endfunction

  // Chorus excursion for the n-th chorus-enabled sample since reset.
  function automatic int lfo_model(input int n);
    int p;
`ifdef CHORUS_LFO_EN
    p = n % (2 * CHOR_DEPTH);
    return (p <= CHOR_DEPTH) ? p : 2 * CHOR_DEPTH - p;
`else
    p = n;
    return p - n;
`endif
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (mix_valid) begin
        valid_count++;
        if (exp_q.size() == 0) check("mix_valid_unexpected", mix_valid, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("mix_out", mix_out, mon_e.mix);
          check("latency", cyc - mon_e.start_cyc, mon_e.lat);
        end
      end
      if (mem_rd) begin
        if (addr_q.size() == 0) check("mem_rd_unexpected", mem_rd, 0);
        else begin
          mon_a = addr_q.pop_front();
          check("mem_addr", mem_addr, mon_a);
        end
      end
    end
  end

  task automatic issue(input logic [11:0] d, input logic [11:0] r, input logic [11:0] c,
                       input bit ren, input bit cen, input logic [15:0] wr, input bit ovr);
    int   ra, ca;
    exp_t e;
    ra = (int'(wr) - REV_DELAY + 65536) % 65536;
    ca = (int'(wr) - (CHOR_BASE + lfo_model(chor_count)) + 65536) % 65536;
    if (ren) mem[ra] = {4'($urandom), r};
    if (cen) mem[ca] = {4'($urandom), c};
    @(posedge clk); #2;
    e.mix       = model_mix(int'(d), int'(r), int'(c), ren, cen);
    e.start_cyc = cyc;
    e.lat       = 2 + (ren ? 2 : 0) + (cen ? 2 : 0);
    exp_q.push_back(e);
    if (ren) addr_q.push_back(16'(ra));
    if (cen) begin
      addr_q.push_back(16'(ca));
      chor_count++;
    end
    dry_sample = d; wr_address = wr; reverb_on = ren; chorus_on = cen; start = 1'b1;
    #1 check("overrun_idle", overrun, 0);
    @(posedge clk); #2;
    start = 1'b0;
    dry_sample = 12'($urandom);
    reverb_on  = 1'($urandom);
    chorus_on  = 1'($urandom);
    if (ovr) begin
      @(posedge clk); #2;
      start = 1'b1;
      #1 check("overrun_busy", overrun, 1);
      @(posedge clk); #2;
      start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("done_timeout_pending", exp_q.size(), 0);
      exp_q.delete();
      addr_q.delete();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; chorus_on = 1'b0; reverb_on = 1'b0;
    wr_address = '0; dry_sample = '0;
    #3 reset = 1'b0;
    #10;
    check("rst_mix_out", mix_out, 0);
    check("rst_mix_valid", mix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_overrun", overrun, 0);
    #10 reset = 1'b1;

    issue(12'h900, 12'hA00, 12'h000, 1, 0, 16'h3000, 0); wait_idle();
    issue(12'hFFF, 12'hFFF, 12'hFFF, 1, 1, 16'h8123, 0); wait_idle();
    issue(12'h000, 12'h000, 12'h000, 1, 1, 16'h4000, 0); wait_idle();
    issue(12'h7FF, 12'h000, 12'h000, 0, 0, 16'h1234, 0); wait_idle();
    issue(12'($urandom), 12'($urandom), 12'h0, 1, 0, 16'h0005, 0); wait_idle();

    for (int i = 0; i < 10; i++) begin
      issue(12'($urandom), 12'($urandom), 12'($urandom), 1'($urandom), 1,
            16'($urandom), 0);
      wait_idle();
    end

    issue(12'($urandom), 12'($urandom), 12'($urandom), 1, 1, 16'h2222, 1); wait_idle();

    // Abort a both-taps sample at cycle 3; LFO also returns to its reset phase.
    issue(12'($urandom), 12'($urandom), 12'($urandom), 1, 1, 16'h6000, 0);
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_mem_rd", mem_rd, 0);
    check("abort_mix_valid", mix_valid, 0);
    exp_q.delete();
    addr_q.delete();
    chor_count = 0;
    vc = valid_count;
    #1 reset = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_valid", valid_count - vc, 0);

    issue(12'($urandom), 12'($urandom), 12'($urandom), 1, 1, 16'h6000, 0); wait_idle();

    for (int i = 0; i < 40; i++) begin
      issue(12'($urandom), 12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom),
            16'($urandom), 0);
      wait_idle();
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
